// File: rtl/lfsr_uart_tx.sv
// lfsr_uart_tx: 8N1/8N2 UART transmitter fed by the prescaled LFSR stage.
// Bytes offered while a frame is in flight are dropped.
module lfsr_uart_tx #(
  parameter int BAUD_DIV  = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] I,
  input  logic       VALID,
  output logic       READY,
  output logic       TX,
  output logic       BUSY
);

  localparam int CW = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          tx_q;
  logic          period_end;

  assign period_end = (cnt == CNT_LAST);
  assign READY      = (state == S_IDLE);
  assign BUSY       = ~READY;
  assign TX         = tx_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx_q  <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (VALID) begin
            sh    <= I;
            cnt   <= '0;
            idx   <= '0;
            state <= S_START;
            tx_q  <= 1'b0;
          end
        end
        S_START: begin
          if (period_end) begin
            cnt   <= '0;
            state <= S_DATA;
            tx_q  <= sh[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (period_end) begin
            cnt <= '0;
            sh  <= sh >> 1;
            if (idx == 3'd7) begin
              idx   <= '0;
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              idx  <= idx + 1'b1;
              tx_q <= sh[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (period_end) begin
            cnt <= '0;
            // idx doubles as the stop-bit counter here
            if (idx == STOP_LAST) begin
              idx   <= '0;
              state <= S_IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// tb_lfsr_uart_tx: directed checks of frame timing, drops and reset
// on a BAUD_DIV=4/1-stop instance and a BAUD_DIV=104/2-stop instance.
module tb_lfsr_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_d, b_d;
  logic       a_valid, b_valid;
  logic       a_ready, a_tx, a_busy;
  logic       b_ready, b_tx, b_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_uart_tx #(.BAUD_DIV(4), .STOP_BITS(1)) u_a (
    .CLK   (clk),
    .RESETN(rst_n),
    .I     (a_d),
    .VALID (a_valid),
    .READY (a_ready),
    .TX    (a_tx),
    .BUSY  (a_busy)
  );

  lfsr_uart_tx #(.BAUD_DIV(104), .STOP_BITS(2)) u_b (
    .CLK   (clk),
    .RESETN(rst_n),
    .I     (b_d),
    .VALID (b_valid),
    .READY (b_ready),
    .TX    (b_tx),
    .BUSY  (b_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; walks the whole frame.
  task automatic frame(input bit sel, input logic [7:0] b,
                       input int bd, input int sb, input int drop_j);
    int p;
    logic e;
    for (int j = 0; j < (9 + sb) * bd; j++) begin
      p = j / bd;
      if (p == 0) e = 1'b0;
      else if (p <= 8) e = b[p-1];
      else e = 1'b1;
      chk("tx_bit", sel ? b_tx : a_tx, e);
      chk("ready_low", sel ? b_ready : a_ready, 0);
      if (drop_j >= 0) begin
        a_valid = (j == drop_j);
        if (j == drop_j) a_d = 8'h99;
      end
      tick;
    end
    chk("ready_high", sel ? b_ready : a_ready, 1);
    chk("busy_low", sel ? b_busy : a_busy, 0);
    chk("tx_idle", sel ? b_tx : a_tx, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_d     = 8'h5A;
    b_d     = 8'h5A;
    repeat (3) begin
      tick;
      chk("rst_tx", a_tx, 1);
      chk("rst_ready", a_ready, 1);
      chk("rst_busy", a_busy, 0);
      chk("rst_b_tx", b_tx, 1);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b1;
    tick;
    chk("post_rst_ready", a_ready, 1);
    chk("post_rst_tx", a_tx, 1);

    // single frame 0xA5
    a_valid = 1'b1;
    a_d     = 8'hA5;
    tick;
    a_valid = 1'b0;
    a_d     = 8'h00;
    frame(1'b0, 8'hA5, 4, 1, -1);

    // back-to-back with VALID held high; I changes after accept
    a_valid = 1'b1;
    a_d     = 8'h01;
    tick;
    a_d = 8'hFF;
    frame(1'b0, 8'h01, 4, 1, -1);
    tick;
    frame(1'b0, 8'hFF, 4, 1, -1);
    a_valid = 1'b0;

    // byte offered mid-frame is dropped
    a_valid = 1'b1;
    a_d     = 8'h3C;
    tick;
    a_valid = 1'b0;
    frame(1'b0, 8'h3C, 4, 1, 9);
    repeat (8) begin
      tick;
      chk("drop_tx_idle", a_tx, 1);
      chk("drop_ready", a_ready, 1);
    end

    // reset during data bit 3 of 0x00
    a_valid = 1'b1;
    a_d     = 8'h00;
    tick;
    a_valid = 1'b0;
    repeat (17) tick;
    chk("mid_bit3", a_tx, 0);
    chk("mid_busy", a_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tx", a_tx, 1);
    chk("async_ready", a_ready, 1);
    tick;
    rst_n   = 1'b1;
    a_valid = 1'b1;
    a_d     = 8'h55;
    tick;
    a_valid = 1'b0;
    frame(1'b0, 8'h55, 4, 1, -1);

    // two stop bits at BAUD_DIV=104
    b_valid = 1'b1;
    b_d     = 8'h80;
    tick;
    b_valid = 1'b0;
    b_d     = 8'h00;
    frame(1'b1, 8'h80, 104, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_uart_tx.md
# lfsr_uart_tx

Serial transmitter that consumes the 8-bit pattern produced by the prescaled LFSR stage and sends each new byte off-board as an 8N1/8N2 UART frame on a single pin. It sits directly downstream of the LFSR shift register: the LFSR parallel output drives `I`, and the prescaler carry-out pulse (the LFSR clock-enable) drives `VALID`. A `READY`/`VALID` handshake lets the block drop LFSR updates that arrive while a frame is still in flight, so no upstream change is needed.

## Interface
- `BAUD_DIV`, 104, CLK cycles per bit period (104 ≈ 115200 baud at 12 MHz); legal range 2..65535
- `STOP_BITS`, 1, number of stop bits per frame; legal values 1 or 2

- `CLK`  in  1  sole clock; all state updates on rising edge
- `RESETN`  in  1  asynchronous, active-low reset
- `I`  in  8  byte to transmit, sampled on accept
- `VALID`  in  1  upstream presents a byte on `I`
- `READY`  out  1  block can accept a byte this cycle
- `TX`  out  1  serial line, idle high, registered
- `BUSY`  out  1  frame in progress; equals `~READY`

## Operation
- The clock is one clock domain and the reset is asynchronous active-low, both as stated in the Interface.
- The FSM has four states:
  - IDLE: `READY`=1, `TX`=1.
  - START: `TX`=0 for one bit period.
  - DATA: `TX`=bit `n` of the captured byte, LSB first, `n`=0..7.
  - STOP: `TX`=1 for `STOP_BITS` bit periods, then back to IDLE.
- Accept: when `VALID`&`READY` is high at a rising edge, the block does all of the following on that edge:
  - captures `I` into the shift register;
  - clears the baud counter;
  - clears the bit index;
  - moves the FSM to START.
- Ignored input: `VALID` in any state other than IDLE is ignored. That byte is lost, with no queueing.
- Baud counter: counts 0..`BAUD_DIV`-1. A bit period ends on the edge where the counter equals `BAUD_DIV`-1; on that edge the counter wraps to 0 and the FSM or bit index advances.
- DATA state: shifts the register right by 1 at the end of each bit period and increments the bit index. After index 7 completes, the FSM moves to STOP.
- STOP state: uses the bit index as a stop-bit counter, cleared on entry. After `STOP_BITS` periods the FSM moves to IDLE.
- Width rules:
  - baud counter is `clog2(BAUD_DIV)` bits;
  - bit index is 3 bits;
  - the counter wraps and never overflows.
- `I` may change freely after the accept edge. The frame uses the captured copy only.
- `VALID` held high continuously: a new byte is accepted each time the FSM returns to IDLE.

## Timing
- Reset values (asynchronous, immediate on `RESETN`=0):
  - FSM state: IDLE
  - `TX`: 1
  - `READY`: 1
  - `BUSY`: 0
  - shift register: 0x00
  - counters: 0
- Reset mid-frame: `TX` goes high without waiting for a clock edge, and the partial frame is abandoned. After `RESETN` rises, the first accept is possible at the first edge.
- Accept at edge k. Measuring from edge k:
  - `TX` falls after edge k (the start bit);
  - data bit `n` is driven from edge k+(1+n)·`BAUD_DIV`;
  - the stop bit starts at edge k+9·`BAUD_DIV`;
  - the FSM enters IDLE at edge k+(9+`STOP_BITS`)·`BAUD_DIV`.
- `READY` is combinational from the state. It is low from edge k until the IDLE return edge, and high in the cycle that follows.
- The earliest next accept is edge k+(9+`STOP_BITS`)·`BAUD_DIV`+1. Back-to-back frames are therefore separated by exactly one CLK cycle of extra idle-high.
- Frame length: (9+`STOP_BITS`)·`BAUD_DIV` cycles, plus a 1-cycle gap.
- Latency: from accept to the first `TX` change is 1 edge.

## Test plan
- Reset: hold `RESETN`=0 with `VALID`=1 → `TX`=1, `READY`=1, `BUSY`=0; no accept occurs while in reset.
- Single frame, `BAUD_DIV`=4, `STOP_BITS`=1, `I`=0xA5 pulsed for 1 cycle → `TX` reads, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1. `READY` is low for exactly 40 cycles and high on cycle 41.
- Back-to-back, `BAUD_DIV`=4, `VALID` held high with 0x01 then 0xFF → two frames, with `TX` high for exactly 4+1 cycles between the second frame's start bit and the first frame's stop-bit start; the second frame carries 0xFF.
- Drop while busy, `BAUD_DIV`=4: accept 0x3C, then pulse `VALID` with 0x99 at cycle 10 → only 0x3C is transmitted; `TX` stays high after the stop bit.
- Reset mid-frame: deassert `RESETN` during data bit 3 of 0x00 → `TX`=1 immediately with no clock edge; after release, an accept of 0x55 produces a clean full frame.
- `STOP_BITS`=2, `BAUD_DIV`=104, LFSR-driven `I`=0x80 → frame length is 1144 cycles, with `TX` high for 208 cycles before `READY` rises.
